// File: rtl/cr16_operand_sequencer.sv
// Operand/opcode entry sequencer: builds NUM_OPERANDS operands, then an opcode, one switch chunk per load press.
// Latency: O_VALID rises 1 cycle after the opcode load event. Define CR16_OPERAND_SEQUENCER_DEBOUNCE_EN to filter I_LOAD.
// Backpressure: the issued set is held until I_READY; load presses during ISSUE are dropped, not queued.
module cr16_operand_sequencer #(
   parameter int DATA_WIDTH      = 16,
   parameter int IN_WIDTH        = 8,
   parameter int OPCODE_WIDTH    = 5,
   parameter int NUM_OPERANDS    = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   localparam int CHUNKS = DATA_WIDTH / IN_WIDTH,
   localparam int TOTAL  = NUM_OPERANDS * CHUNKS,
   localparam int SW     = $clog2(TOTAL + 2)
) (
   input  logic                               CLK,
   input  logic                               RST,
   input  logic [IN_WIDTH-1:0]                I_DATA,
   input  logic                               I_LOAD,
   input  logic                               I_READY,
   output logic                               O_VALID,
   output logic [NUM_OPERANDS*DATA_WIDTH-1:0] O_OPERANDS,
   output logic [OPCODE_WIDTH-1:0]            O_OPCODE,
   output logic [SW-1:0]                      O_STEP
);

   localparam logic [SW-1:0] LAST_STEP  = SW'(TOTAL - 1);
   localparam logic [SW-1:0] ISSUE_STEP = SW'(TOTAL + 1);

   if ((DATA_WIDTH % IN_WIDTH) != 0 || OPCODE_WIDTH > IN_WIDTH || NUM_OPERANDS < 1
       || DEBOUNCE_CYCLES < 1) begin : g_bad_params
      $error("cr16_operand_sequencer: illegal parameter combination");
   end

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_OPC   = 2'd1,
      S_ISSUE = 2'd2
   } state_t;

   state_t                             state_q, state_d;
   logic [SW-1:0]                      step_q, step_d;
   logic [NUM_OPERANDS*DATA_WIDTH-1:0] stage_q, stage_d;
   logic [OPCODE_WIDTH-1:0]            opc_q, opc_d;
   logic [NUM_OPERANDS*DATA_WIDTH-1:0] shadow_ops_q;
   logic [OPCODE_WIDTH-1:0]            shadow_opc_q;
   logic                               shadow_ld;
   logic                               load_filt;
   logic                               load_prev_q;
   logic                               load_evt;

`ifdef CR16_OPERAND_SEQUENCER_DEBOUNCE_EN
   localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
   logic [DBW-1:0] db_cnt_q;
   logic           db_lvl_q;

   // Filtered level flips only after the raw level has differed for DEBOUNCE_CYCLES samples in a row.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         db_cnt_q <= '0;
         db_lvl_q <= 1'b0;
      end else if (I_LOAD == db_lvl_q) begin
         db_cnt_q <= '0;
      end else if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
         db_cnt_q <= '0;
         db_lvl_q <= I_LOAD;
      end else begin
         db_cnt_q <= db_cnt_q + 1'b1;
      end
   end

   assign load_filt = db_lvl_q;
`else
   assign load_filt = I_LOAD;
`endif

   assign load_evt = load_filt & ~load_prev_q;

   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      stage_d   = stage_q;
      opc_d     = opc_q;
      shadow_ld = 1'b0;
      case (state_q)
         S_LOAD: begin
            if (load_evt) begin
               // Chunk 0 of each operand lands in its most significant IN_WIDTH bits.
               for (int i = 0; i < TOTAL; i++) begin
                  if (step_q == SW'(i)) begin
                     stage_d[(i / CHUNKS) * DATA_WIDTH + (CHUNKS - 1 - (i % CHUNKS)) * IN_WIDTH +: IN_WIDTH]
                        = I_DATA;
                  end
               end
               step_d = step_q + 1'b1;
               if (step_q == LAST_STEP) begin
                  state_d = S_OPC;
               end
            end
         end
         S_OPC: begin
            if (load_evt) begin
               opc_d     = I_DATA[OPCODE_WIDTH-1:0];
               step_d    = ISSUE_STEP;
               state_d   = S_ISSUE;
               shadow_ld = 1'b1;
            end
         end
         S_ISSUE: begin
            if (I_READY) begin
               state_d = S_LOAD;
               step_d  = '0;
            end
         end
         default: begin
            state_d = S_LOAD;
            step_d  = '0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q      <= S_LOAD;
         step_q       <= '0;
         stage_q      <= '0;
         opc_q        <= '0;
         shadow_ops_q <= '0;
         shadow_opc_q <= '0;
         load_prev_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         stage_q     <= stage_d;
         opc_q       <= opc_d;
         load_prev_q <= load_filt;
         // Shadow loads together with the opcode so outputs are valid when O_VALID rises.
         if (shadow_ld) begin
            shadow_ops_q <= stage_d;
            shadow_opc_q <= opc_d;
         end
      end
   end

   assign O_VALID    = (state_q == S_ISSUE);
   assign O_OPERANDS = shadow_ops_q;
   assign O_OPCODE   = shadow_opc_q;
   assign O_STEP     = step_q;

endmodule

// File: tb/tb_cr16_operand_sequencer.sv
// Directed bench for cr16_operand_sequencer (default build, debounce disabled).
module tb_cr16_operand_sequencer;

   logic        CLK;
   logic        RST;
   logic [7:0]  I_DATA;
   logic        I_LOAD;
   logic        I_READY;
   logic        O_VALID;
   logic [31:0] O_OPERANDS;
   logic [4:0]  O_OPCODE;
   logic [2:0]  O_STEP;

   typedef struct packed {
      logic [31:0] ops;
      logic [4:0]  opc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   cr16_operand_sequencer dut (
      .CLK       (CLK),
      .RST       (RST),
      .I_DATA    (I_DATA),
      .I_LOAD    (I_LOAD),
      .I_READY   (I_READY),
      .O_VALID   (O_VALID),
      .O_OPERANDS(O_OPERANDS),
      .O_OPCODE  (O_OPCODE),
      .O_STEP    (O_STEP)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Called just after a rising edge with I_LOAD low; the event is taken at the next edge.
   task automatic press(input logic [7:0] d, input bit idle);
      I_DATA = d;
      I_LOAD = 1'b1;
      @(posedge CLK); #1;
      I_LOAD = 1'b0;
      if (idle) begin
         @(posedge CLK); #1;
      end
   endtask

   task automatic check_issue(input string tag);
      exp_t e;
      int   n = 0;
      while (O_VALID !== 1'b1 && n < 8) begin
         @(posedge CLK); #1;
         n++;
      end
      chk({tag, "_valid"}, 64'(O_VALID), 64'd1);
      if (exp_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 64'd0, 64'd1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_ops"}, 64'(O_OPERANDS), 64'(e.ops));
         chk({tag, "_opc"}, 64'(O_OPCODE), 64'(e.opc));
      end
   endtask

   initial begin
      RST     = 1'b0;
      I_DATA  = '0;
      I_LOAD  = 1'b0;
      I_READY = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_valid", 64'(O_VALID), 64'd0);
      chk("rst_step", 64'(O_STEP), 64'd0);
      chk("rst_ops", 64'(O_OPERANDS), 64'd0);
      chk("rst_opc", 64'(O_OPCODE), 64'd0);
      RST = 1'b1;
      @(posedge CLK); #1;

      // First set, MSB-first chunk order, one-cycle issue latency.
      press(8'h12, 1);
      chk("s1_step1", 64'(O_STEP), 64'd1);
      press(8'h34, 1);
      press(8'h56, 1);
      press(8'h78, 1);
      chk("s1_step4", 64'(O_STEP), 64'd4);
      chk("s1_pre_valid", 64'(O_VALID), 64'd0);
      exp_q.push_back('{ops: 32'h5678_1234, opc: 5'h05});
      press(8'h05, 0);
      chk("s1_latency", 64'(O_VALID), 64'd1);
      check_issue("s1");
      chk("s1_step5", 64'(O_STEP), 64'd5);

      // Stall 20 cycles while pressing; nothing may move.
      for (int i = 0; i < 10; i++) press(8'h5A + 8'(i), 1);
      chk("stall_valid", 64'(O_VALID), 64'd1);
      chk("stall_step", 64'(O_STEP), 64'd5);
      chk("stall_ops", 64'(O_OPERANDS), 64'h5678_1234);
      chk("stall_opc", 64'(O_OPCODE), 64'h05);

      // Ready together with a press: transfer completes, press is dropped.
      I_READY = 1'b1;
      I_DATA  = 8'h77;
      I_LOAD  = 1'b1;
      @(posedge CLK); #1;
      I_READY = 1'b0;
      chk("hs_valid", 64'(O_VALID), 64'd0);
      chk("hs_step", 64'(O_STEP), 64'd0);
      @(posedge CLK); #1;
      chk("hs_drop_step", 64'(O_STEP), 64'd0);
      I_LOAD = 1'b0;
      @(posedge CLK); #1;

      // Held button yields a single event.
      I_DATA = 8'hAB;
      I_LOAD = 1'b1;
      repeat (10) @(posedge CLK);
      #1;
      I_LOAD = 1'b0;
      chk("hold_step", 64'(O_STEP), 64'd1);
      @(posedge CLK); #1;
      chk("hold_step_after", 64'(O_STEP), 64'd1);

      // Second set: shadow outputs keep the first set during entry.
      press(8'h9A, 1);
      press(8'hBC, 1);
      chk("s2_shadow_mid", 64'(O_OPERANDS), 64'h5678_1234);
      press(8'hDE, 1);
      chk("s2_step4", 64'(O_STEP), 64'd4);
      chk("s2_shadow_opc", 64'(O_OPCODE), 64'h05);
      exp_q.push_back('{ops: 32'hBCDE_AB9A, opc: 5'h1B});
      press(8'h3B, 0);
      check_issue("s2");
      I_READY = 1'b1;
      @(posedge CLK); #1;
      I_READY = 1'b0;
      chk("s2_done_valid", 64'(O_VALID), 64'd0);

      // Asynchronous reset in the middle of entry.
      press(8'h11, 1);
      press(8'h22, 1);
      press(8'h33, 1);
      chk("ar_step3", 64'(O_STEP), 64'd3);
      #2;
      RST = 1'b0;
      #1;
      chk("ar_step", 64'(O_STEP), 64'd0);
      chk("ar_ops", 64'(O_OPERANDS), 64'd0);
      chk("ar_opc", 64'(O_OPCODE), 64'd0);
      chk("ar_valid", 64'(O_VALID), 64'd0);
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;

      // Ready held high outside ISSUE is ignored; opcode takes the low 5 bits.
      I_READY = 1'b1;
      press(8'h01, 1);
      press(8'h02, 1);
      press(8'h03, 1);
      press(8'h04, 1);
      chk("s3_step4", 64'(O_STEP), 64'd4);
      chk("s3_pre_valid", 64'(O_VALID), 64'd0);
      exp_q.push_back('{ops: 32'h0304_0102, opc: 5'h1F});
      press(8'hFF, 0);
      check_issue("s3");
      @(posedge CLK); #1;
      chk("s3_done_valid", 64'(O_VALID), 64'd0);
      chk("s3_done_step", 64'(O_STEP), 64'd0);
      chk("s3_hold_ops", 64'(O_OPERANDS), 64'h0304_0102);
      I_READY = 1'b0;

      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
